// File: rtl/seq_mult_ctrl_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
interface seq_mult_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 G;
   logic                 Signed;
   logic                 Abort;
   logic [WIDTH-1:0]     Mcand;
   logic [WIDTH-1:0]     Mplier;
   logic [2*WIDTH-1:0]   P;
   logic                 Busy;
   logic                 Done;

   // User logic side: issues requests and operands, consumes the product.
   modport master (
      output G, Signed, Abort, Mcand, Mplier,
      input  P, Busy, Done
   );

   // Multiplier side.
   modport slave (
      input  G, Signed, Abort, Mcand, Mplier,
      output P, Busy, Done
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one add+shift per clock over WIDTH
// iterations, sign handled by multiplying magnitudes and negating at the end.
module seq_mult_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   seq_mult_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 done_q, done_d;

   // Carry-extended partial sum; its top bit is the carry C that the
   // following right shift moves into A, so C never needs its own flop.
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     addend;
   logic [2*WIDTH-1:0]   prod;

   // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
   // which still fits the unsigned WIDTH-bit register.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                            input logic             sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   // Next-state and datapath update; Abort outranks G in IDLE and cancels CALC/FIX.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      p_d     = p_q;
      done_d  = 1'b0;
      addend  = q_q[0] ? b_q : '0;
      sum     = {1'b0, a_q} + {1'b0, addend};
      prod    = {a_q, q_q};

      case (state_q)
         S_IDLE: begin
            if (bus.G && !bus.Abort) begin
               b_d     = mag(bus.Mcand, bus.Signed);
               q_d     = mag(bus.Mplier, bus.Signed);
               neg_d   = bus.Signed & (bus.Mcand[WIDTH-1] ^ bus.Mplier[WIDTH-1]);
               a_d     = '0;
               cnt_d   = CNT_INIT;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (bus.Abort) begin
               state_d = S_IDLE;
            end else begin
               a_d   = sum[WIDTH:1];
               q_d   = {sum[0], q_q[WIDTH-1:1]};
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.Abort) begin
               p_d    = neg_q ? -prod : prod;
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared immediately on Reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign bus.Busy = (state_q != S_IDLE);
   assign bus.P    = p_q;
   assign bus.Done = done_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with WIDTH=8.
module tb_seq_mult_ctrl;

   logic Clk;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   seq_mult_ctrl_if #(.WIDTH(8)) bus ();

   seq_mult_ctrl #(.WIDTH(8), .CW(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic        sgn;
      logic [7:0]  mc;
      logic [7:0]  mp;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Start one operation, count Busy cycles, check Done pulse and product.
   task automatic run_op(input string name, input logic sgn, input logic [7:0] mc,
                         input logic [7:0] mp, input logic [15:0] exp, input bit disturb);
      int busy;
      bus.Signed = sgn;
      bus.Mcand  = mc;
      bus.Mplier = mp;
      bus.G      = 1'b1;
      step();
      bus.G = 1'b0;
      if (disturb) begin
         bus.Mcand  = 8'h55;
         bus.Mplier = 8'hAA;
         bus.Signed = ~sgn;
      end
      busy = 0;
      while (bus.Busy && busy < 20) begin
         busy++;
         if (disturb && busy == 3) bus.G = 1'b1;
         if (disturb && busy == 4) bus.G = 1'b0;
         step();
      end
      bus.G = 1'b0;
      check({name, "_busy_cycles"}, busy, 9);
      check({name, "_done"}, bus.Done, 1'b1);
      check({name, "_p"}, bus.P, exp);
      step();
      check({name, "_done_drop"}, bus.Done, 1'b0);
   endtask

   initial begin
      int n;
      int seen_done;

      vecs[0] = '{"u13x11",    1'b0, 8'd13,  8'd11,  16'h008F};
      vecs[1] = '{"u255x255",  1'b0, 8'hFF,  8'hFF,  16'hFE01};
      vecs[2] = '{"sm1xm1",    1'b1, 8'hFF,  8'hFF,  16'h0001};
      vecs[3] = '{"sm128xm128",1'b1, 8'h80,  8'h80,  16'h4000};
      vecs[4] = '{"sm128x127", 1'b1, 8'h80,  8'h7F,  16'hC080};
      vecs[5] = '{"s7xm3",     1'b1, 8'd7,   8'hFD,  16'hFFEB};
      vecs[6] = '{"s0xm5",     1'b1, 8'd0,   8'hFB,  16'h0000};
      vecs[7] = '{"u128x127",  1'b0, 8'h80,  8'h7F,  16'h3F80};
      vecs[8] = '{"u0x200",    1'b0, 8'd0,   8'd200, 16'h0000};

      Reset      = 1'b1;
      bus.G      = 1'b0;
      bus.Signed = 1'b0;
      bus.Abort  = 1'b0;
      bus.Mcand  = '0;
      bus.Mplier = '0;
      #12;
      check("reset_p", bus.P, 16'h0000);
      check("reset_busy", bus.Busy, 1'b0);
      check("reset_done", bus.Done, 1'b0);
      Reset = 1'b0;
      step();

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].name, vecs[i].sgn, vecs[i].mc, vecs[i].mp, vecs[i].exp, 1'b0);
      end

      // G pulse mid-CALC and operand changes after start must not matter.
      run_op("disturb_s7xm3", 1'b1, 8'd7, 8'hFD, 16'hFFEB, 1'b1);

      // Abort on the 4th CALC edge: back to IDLE, no Done, P untouched.
      bus.Signed = 1'b0;
      bus.Mcand  = 8'd13;
      bus.Mplier = 8'd11;
      bus.G      = 1'b1;
      step();
      bus.G = 1'b0;
      step();
      step();
      step();
      check("abort_busy_before", bus.Busy, 1'b1);
      bus.Abort = 1'b1;
      step();
      bus.Abort = 1'b0;
      check("abort_busy", bus.Busy, 1'b0);
      check("abort_done", bus.Done, 1'b0);
      check("abort_p", bus.P, 16'hFFEB);
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.Done) seen_done++;
      end
      check("abort_no_late_done", seen_done, 0);
      check("abort_p_hold", bus.P, 16'hFFEB);

      // Abort coincident with G in IDLE blocks the start.
      bus.Abort = 1'b1;
      bus.G     = 1'b1;
      step();
      check("abort_g_busy", bus.Busy, 1'b0);
      bus.Abort = 1'b0;
      bus.G     = 1'b0;
      step();
      check("abort_g_busy2", bus.Busy, 1'b0);
      check("abort_g_p", bus.P, 16'hFFEB);

      // G held high: a new start on every Done cycle, Done every 10th cycle.
      bus.Signed = 1'b0;
      bus.Mcand  = 8'd13;
      bus.Mplier = 8'd11;
      bus.G      = 1'b1;
      step();
      for (int i = 1; i <= 30; i++) begin
         step();
         check($sformatf("b2b_done_%0d", i), bus.Done, (i % 10 == 9));
         if (i % 10 == 9) check($sformatf("b2b_p_%0d", i), bus.P, 16'h008F);
         if (i % 10 == 9) check($sformatf("b2b_busy_%0d", i), bus.Busy, 1'b0);
      end
      bus.G = 1'b0;
      n = 0;
      while (bus.Busy && n < 20) begin
         n++;
         step();
      end
      check("b2b_drain", bus.Busy, 1'b0);
      step();

      // Asynchronous reset between edges mid-CALC.
      bus.Signed = 1'b1;
      bus.Mcand  = 8'h80;
      bus.Mplier = 8'h80;
      bus.G      = 1'b1;
      step();
      bus.G = 1'b0;
      step();
      step();
      #2;
      Reset = 1'b1;
      #1;
      check("areset_p", bus.P, 16'h0000);
      check("areset_busy", bus.Busy, 1'b0);
      check("areset_done", bus.Done, 1'b0);
      @(posedge Clk);
      #3;
      Reset = 1'b0;
      step();
      check("areset_idle", bus.Busy, 1'b0);
      run_op("post_reset_u13x11", 1'b0, 8'd13, 8'd11, 16'h008F, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
